// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared state encodings and timing constants for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_SETTLE = 2'd2
    } arb_state_t;

    // Cycles spent in SETTLE so the FIFO's registered count catches up
    localparam int unsigned C_SETTLE_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority picker (lowest index at/after ptr).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any_req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int C_IDX_W = $clog2(NUM_REQ);

    int unsigned w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last
    always_comb begin
        any_req   = |req;
        grant     = '0;
        grant_idx = '0;
        w_idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = (int'(ptr) + i) % NUM_REQ;
            if (req[C_IDX_W'(w_idx)]) begin
                grant                   = '0;
                grant[C_IDX_W'(w_idx)]  = 1'b1;
                grant_idx               = C_IDX_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic [CNT_WIDTH-1:0]          fifo_wr_data_count,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          burst_done
);

    localparam int C_IDX_W  = $clog2(NUM_REQ);
    localparam int C_BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int C_SET_W  = (C_SETTLE_CYCLES > 1) ? $clog2(C_SETTLE_CYCLES) : 1;

    localparam logic [C_BEAT_W-1:0]  C_LAST_BEAT   = C_BEAT_W'(BURST_LEN - 1);
    localparam logic [C_SET_W-1:0]   C_SETTLE_LAST = C_SET_W'(C_SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH       = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_BURST       = CNT_WIDTH'(BURST_LEN);
    localparam logic [C_IDX_W-1:0]   C_LAST_IDX    = C_IDX_W'(NUM_REQ - 1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [C_IDX_W-1:0]   r_grant_id;
    logic [NUM_REQ-1:0]   r_grant_oh;
    logic [C_IDX_W-1:0]   r_rr_ptr;
    logic [C_BEAT_W-1:0]  r_beat_cnt;
    logic [C_SET_W-1:0]   r_settle_cnt;
    logic                 r_burst_done;

    logic [CNT_WIDTH-1:0] w_space;
    logic                 w_any_req;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [C_IDX_W-1:0]   w_win_idx;
    logic                 w_beat;
    logic                 w_close;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .any_req   (w_any_req),
        .grant     (w_win_oh),
        .grant_idx (w_win_idx)
    );

    always_comb begin
        w_space     = C_DEPTH - fifo_wr_data_count;
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_close     = 1'b0;
        req_ready   = '0;
        fifo_wr_en  = 1'b0;
        fifo_din    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req && (w_space >= C_BURST) && !fifo_full)
                    w_state_nxt = ST_BURST;
            end
            ST_BURST: begin
                req_ready  = fifo_full ? '0 : r_grant_oh;
                fifo_din   = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
                w_beat     = req_valid[r_grant_id] & ~fifo_full;
                fifo_wr_en = w_beat;
                w_close    = w_beat & (req_last[r_grant_id] | (r_beat_cnt == C_LAST_BEAT));
                if (w_close)
                    w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle_cnt == C_SETTLE_LAST)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_grant_id   <= '0;
            r_grant_oh   <= '0;
            r_rr_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_settle_cnt <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= w_close;
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_BURST)) begin
                r_grant_id <= w_win_idx;
                r_grant_oh <= w_win_oh;
                r_beat_cnt <= '0;
            end
            if (w_beat)
                r_beat_cnt <= r_beat_cnt + 1'b1;
            // The channel that just finished drops to lowest priority
            if (w_close) begin
                r_rr_ptr     <= (r_grant_id == C_LAST_IDX) ? '0 : r_grant_id + 1'b1;
                r_settle_cnt <= '0;
            end
            if (r_state == ST_SETTLE)
                r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    assign grant_id   = r_grant_id;
    assign busy       = (r_state != ST_IDLE);
    assign burst_done = r_burst_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter with a burst-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 64;
    localparam int FIFO_DEPTH = 16;
    localparam int BURST_LEN  = 4;
    localparam int CNT_WIDTH  = 5;
    localparam int MAXB       = 64;

    logic                          sys_clk = 1'b0;
    logic                          rstn = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]            req_last = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          fifo_wr_en;
    logic                          fifo_full = 1'b0;
    logic [CNT_WIDTH-1:0]          fifo_wr_data_count = '0;
    logic [1:0]                    grant_id;
    logic                          busy;
    logic                          burst_done;

    int total = 0;
    int bad   = 0;

    logic [63:0] bdata [NUM_REQ][MAXB];
    logic        blast [NUM_REQ][MAXB];
    int          nb    [NUM_REQ];
    int          pos   [NUM_REQ];
    logic        hold  [NUM_REQ];

    always #5 sys_clk = ~sys_clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BURST_LEN  (BURST_LEN),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .sys_clk            (sys_clk),
        .rstn               (rstn),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_last           (req_last),
        .req_ready          (req_ready),
        .fifo_din           (fifo_din),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_full          (fifo_full),
        .fifo_wr_data_count (fifo_wr_data_count),
        .grant_id           (grant_id),
        .busy               (busy),
        .burst_done         (burst_done)
    );

    // ---------------- producer driver ----------------
    task automatic drive_inputs();
        for (int c = 0; c < NUM_REQ; c++) begin
            if (pos[c] < nb[c]) begin
                req_valid[c] = !hold[c];
                req_data[c*DATA_WIDTH +: DATA_WIDTH] = bdata[c][pos[c]];
                req_last[c] = blast[c][pos[c]];
            end else begin
                req_valid[c] = 1'b0;
                req_data[c*DATA_WIDTH +: DATA_WIDTH] = {$urandom, $urandom};
                req_last[c] = 1'($urandom);
            end
        end
    endtask

    task automatic push_beat(input int c, input logic [63:0] d, input logic l);
        bdata[c][nb[c]] = d;
        blast[c][nb[c]] = l;
        nb[c]++;
    endtask

    task automatic clear_producers();
        for (int c = 0; c < NUM_REQ; c++) begin
            nb[c] = 0; pos[c] = 0; hold[c] = 1'b0;
        end
    endtask

    // Samples at the falling edge; reports which channel (if any) handed over a beat
    task automatic step(output int acc, output logic [63:0] ad, output logic al);
        @(negedge sys_clk);
        acc = -1; ad = '0; al = 1'b0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (req_valid[c] && req_ready[c]) begin
                acc = c; ad = bdata[c][pos[c]]; al = blast[c][pos[c]];
            end
        end
        if (acc >= 0) pos[acc]++;
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
        drive_inputs();
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        fifo_full = 1'b0;
        fifo_wr_data_count = '0;
        clear_producers();
        drive_inputs();
        repeat (2) @(posedge sys_clk);
        #1 rstn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_producers();
        push_beat(1, 64'h1111, 1'b0);
        drive_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2;
        total++; if (req_ready !== 4'b0)   begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
        total++; if (fifo_wr_en !== 1'b0)  begin bad++; $display("FAIL rst_wr_en got=%b exp=0", fifo_wr_en); end
        total++; if (fifo_din !== 64'h0)   begin bad++; $display("FAIL rst_din got=%h exp=0", fifo_din); end
        total++; if (grant_id !== 2'd0)    begin bad++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (burst_done !== 1'b0)  begin bad++; $display("FAIL rst_done got=%b exp=0", burst_done); end
    endtask

    task automatic test_single_burst();
        int acc; logic [63:0] ad; logic al;
        apply_reset();
        for (int b = 0; b < 4; b++) push_beat(2, {$urandom, $urandom}, b == 3);
        drive_inputs();
        for (int k = 0; k < 8; k++) begin
            step(acc, ad, al);
            total++; if (acc !== ((k >= 1 && k <= 4) ? 2 : -1)) begin bad++; $display("FAIL single_acc k=%0d got=%0d", k, acc); end
            total++; if (fifo_wr_en !== (k >= 1 && k <= 4)) begin bad++; $display("FAIL single_wr_en k=%0d got=%b", k, fifo_wr_en); end
            if (k >= 1 && k <= 4) begin
                total++; if (fifo_din !== bdata[2][k-1]) begin bad++; $display("FAIL single_din k=%0d got=%h exp=%h", k, fifo_din, bdata[2][k-1]); end
                total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
                total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
            end
            total++; if (burst_done !== (k == 5)) begin bad++; $display("FAIL single_done k=%0d got=%b", k, burst_done); end
            total++; if (busy !== (k >= 1 && k <= 6)) begin bad++; $display("FAIL single_busy k=%0d got=%b", k, busy); end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        int acc; logic [63:0] ad; logic al;
        int exp_ch[$]; logic [63:0] exp_d[$];
        int e_c; logic [63:0] e_d;
        int n; int close_cyc; logic prev_close;
        apply_reset();
        for (int c = 0; c < NUM_REQ; c++)
            for (int b = 0; b < 8; b++) push_beat(c, {$urandom, $urandom}, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_REQ; c++)
                for (int b = 0; b < 4; b++) begin
                    exp_ch.push_back(c); exp_d.push_back(bdata[c][r*4+b]);
                end
        drive_inputs();
        n = 0; close_cyc = 0; prev_close = 1'b0;
        for (int cyc = 0; cyc < 120 && exp_ch.size() > 0; cyc++) begin
            step(acc, ad, al);
            total++; if (burst_done !== prev_close) begin bad++; $display("FAIL rr_done cyc=%0d got=%b exp=%b", cyc, burst_done, prev_close); end
            total++; if (fifo_wr_en !== (acc >= 0)) begin bad++; $display("FAIL rr_wr_en cyc=%0d got=%b", cyc, fifo_wr_en); end
            prev_close = 1'b0;
            if (acc >= 0) begin
                e_c = exp_ch.pop_front(); e_d = exp_d.pop_front();
                total++; if (acc !== e_c) begin bad++; $display("FAIL rr_channel got=%0d exp=%0d", acc, e_c); end
                total++; if (fifo_din !== e_d) begin bad++; $display("FAIL rr_din got=%h exp=%h", fifo_din, e_d); end
                if (n % 4 == 0 && n > 0) begin
                    total++; if (cyc !== close_cyc + 4) begin bad++; $display("FAIL rr_gap got=%0d exp=%0d", cyc, close_cyc + 4); end
                end
                if (n % 4 == 3) begin close_cyc = cyc; prev_close = 1'b1; end
                n++;
            end
            next_cycle();
        end
        total++; if (exp_ch.size() != 0) begin bad++; $display("FAIL rr_incomplete got=%0d beats left exp=0", exp_ch.size()); end
    endtask

    task automatic test_space_gate();
        int acc; logic [63:0] ad; logic al;
        apply_reset();
        for (int b = 0; b < 4; b++) push_beat(0, {$urandom, $urandom}, b == 3);
        fifo_wr_data_count = 5'd13;
        drive_inputs();
        for (int k = 0; k < 6; k++) begin
            step(acc, ad, al);
            total++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin bad++; $display("FAIL gate_space3 got busy=%b wr=%b exp=0", busy, fifo_wr_en); end
            next_cycle();
        end
        fifo_wr_data_count = 5'd0; fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(acc, ad, al);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL gate_full_idle got=%b exp=0", busy); end
            next_cycle();
        end
        fifo_full = 1'b0; fifo_wr_data_count = 5'd12;
        step(acc, ad, al);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gate_pre_grant got=%b exp=0", busy); end
        next_cycle();
        step(acc, ad, al);
        total++; if (acc !== 0 || busy !== 1'b1) begin bad++; $display("FAIL gate_grant got acc=%0d busy=%b exp 0/1", acc, busy); end
        total++; if (fifo_din !== bdata[0][0]) begin bad++; $display("FAIL gate_din got=%h exp=%h", fifo_din, bdata[0][0]); end
        next_cycle();
        fifo_full = 1'b1;
        step(acc, ad, al);
        total++; if (req_ready !== 4'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gate_full_burst got ready=%b wr=%b busy=%b", req_ready, fifo_wr_en, busy); end
        next_cycle();
        fifo_full = 1'b0;
        step(acc, ad, al);
        total++; if (acc !== 0 || fifo_din !== bdata[0][1]) begin bad++; $display("FAIL gate_resume got acc=%0d din=%h exp=%h", acc, fifo_din, bdata[0][1]); end
    endtask

    task automatic test_stall();
        int acc; logic [63:0] ad; logic al;
        apply_reset();
        for (int b = 0; b < 4; b++) push_beat(1, {$urandom, $urandom}, b == 3);
        drive_inputs();
        for (int k = 0; k < 3; k++) begin
            step(acc, ad, al);
            if (k > 0) begin
                total++; if (acc !== 1) begin bad++; $display("FAIL stall_pre k=%0d got=%0d exp=1", k, acc); end
            end
            if (k == 2) hold[1] = 1'b1;
            next_cycle();
        end
        for (int k = 0; k < 5; k++) begin
            step(acc, ad, al);
            total++; if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd1) begin bad++; $display("FAIL stall_hold got wr=%b busy=%b grant=%0d", fifo_wr_en, busy, grant_id); end
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_ready got=%b exp=0010", req_ready); end
            if (k == 4) hold[1] = 1'b0;
            next_cycle();
        end
        for (int k = 2; k < 4; k++) begin
            step(acc, ad, al);
            total++; if (acc !== 1 || fifo_din !== bdata[1][k]) begin bad++; $display("FAIL stall_resume got acc=%0d din=%h exp=%h", acc, fifo_din, bdata[1][k]); end
            next_cycle();
        end
        step(acc, ad, al);
        total++; if (burst_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", burst_done); end
    endtask

    task automatic test_last_early();
        int acc; logic [63:0] ad; logic al;
        int exp_acc; logic [63:0] exp_d;
        apply_reset();
        push_beat(0, {$urandom, $urandom}, 1'b1);
        push_beat(0, {$urandom, $urandom}, 1'b1);
        push_beat(1, {$urandom, $urandom}, 1'b0);
        push_beat(1, {$urandom, $urandom}, 1'b1);
        drive_inputs();
        for (int k = 0; k < 13; k++) begin
            step(acc, ad, al);
            case (k)
                1:       begin exp_acc = 0;  exp_d = bdata[0][0]; end
                5:       begin exp_acc = 1;  exp_d = bdata[1][0]; end
                6:       begin exp_acc = 1;  exp_d = bdata[1][1]; end
                10:      begin exp_acc = 0;  exp_d = bdata[0][1]; end
                default: begin exp_acc = -1; exp_d = '0; end
            endcase
            total++; if (acc !== exp_acc) begin bad++; $display("FAIL early_acc k=%0d got=%0d exp=%0d", k, acc, exp_acc); end
            if (exp_acc >= 0) begin
                total++; if (fifo_din !== exp_d) begin bad++; $display("FAIL early_din k=%0d got=%h exp=%h", k, fifo_din, exp_d); end
            end
            total++; if (burst_done !== (k == 2 || k == 7 || k == 11)) begin bad++; $display("FAIL early_done k=%0d got=%b", k, burst_done); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        int acc; logic [63:0] ad; logic al;
        apply_reset();
        push_beat(2, {$urandom, $urandom}, 1'b1);
        for (int b = 0; b < 4; b++) push_beat(3, {$urandom, $urandom}, b == 3);
        drive_inputs();
        for (int k = 0; k < 7; k++) begin
            step(acc, ad, al);
            if (k == 1) begin
                total++; if (acc !== 2) begin bad++; $display("FAIL rmid_first got=%0d exp=2", acc); end
            end
            if (k == 5 || k == 6) begin
                total++; if (acc !== 3) begin bad++; $display("FAIL rmid_beat k=%0d got=%0d exp=3", k, acc); end
            end
            if (k < 6) next_cycle();
        end
        #2 rstn = 1'b0;
        #1;
        total++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async got wr=%b ready=%b busy=%b exp 0", fifo_wr_en, req_ready, busy); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rmid_grant got=%0d exp=0", grant_id); end
        repeat (2) @(posedge sys_clk);
        clear_producers();
        for (int b = 0; b < 2; b++) push_beat(0, {$urandom, $urandom}, b == 1);
        for (int b = 0; b < 2; b++) push_beat(3, {$urandom, $urandom}, b == 1);
        #1 rstn = 1'b1;
        drive_inputs();
        step(acc, ad, al);
        next_cycle();
        step(acc, ad, al);
        total++; if (acc !== 0 || grant_id !== 2'd0) begin bad++; $display("FAIL rmid_restart got acc=%0d grant=%0d exp=0", acc, grant_id); end
    endtask

    // Expected write stream comes from replaying whole bursts in round-robin order
    task automatic test_random();
        int acc; logic [63:0] ad; logic al;
        int exp_ch[$]; logic [63:0] exp_d[$];
        int e_c; logic [63:0] e_d;
        int mc [NUM_REQ];
        logic mid [NUM_REQ];
        int ptr; int w; logic l; logic prev_close; int nbur; int len;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            for (int c = 0; c < NUM_REQ; c++) begin
                nbur = $urandom_range(0, 3);
                for (int b = 0; b < nbur; b++) begin
                    len = $urandom_range(1, BURST_LEN);
                    for (int j = 0; j < len; j++) push_beat(c, {$urandom, $urandom}, j == len - 1);
                end
                mc[c] = 0; mid[c] = 1'b0;
            end
            ptr = 0;
            for (int b = 0; b < MAXB; b++) begin
                w = -1;
                for (int off = 0; off < NUM_REQ; off++)
                    if (w < 0 && mc[(ptr + off) % NUM_REQ] < nb[(ptr + off) % NUM_REQ]) w = (ptr + off) % NUM_REQ;
                if (w < 0) break;
                l = 1'b0;
                while (!l) begin
                    exp_ch.push_back(w); exp_d.push_back(bdata[w][mc[w]]);
                    l = blast[w][mc[w]]; mc[w]++;
                end
                ptr = (w + 1) % NUM_REQ;
            end
            drive_inputs();
            prev_close = 1'b0;
            for (int cyc = 0; cyc < 300 && exp_ch.size() > 0; cyc++) begin
                step(acc, ad, al);
                total++; if (!$onehot0(req_ready)) begin bad++; $display("FAIL rand_onehot got=%b", req_ready); end
                total++; if (burst_done !== prev_close) begin bad++; $display("FAIL rand_done got=%b exp=%b", burst_done, prev_close); end
                total++; if (fifo_wr_en !== (acc >= 0)) begin bad++; $display("FAIL rand_wr_en got=%b exp=%b", fifo_wr_en, acc >= 0); end
                if (acc >= 0) begin
                    e_c = exp_ch.pop_front(); e_d = exp_d.pop_front();
                    total++; if (acc !== e_c || fifo_din !== e_d) begin bad++; $display("FAIL rand_beat got ch=%0d din=%h exp ch=%0d din=%h", acc, fifo_din, e_c, e_d); end
                    mid[acc] = !al;
                end
                prev_close = (acc >= 0) && al;
                for (int c = 0; c < NUM_REQ; c++) hold[c] = mid[c] && ($urandom_range(0, 3) == 0);
                fifo_wr_data_count = CNT_WIDTH'($urandom_range(0, FIFO_DEPTH - BURST_LEN));
                next_cycle();
            end
            total++; if (exp_ch.size() != 0) begin bad++; $display("FAIL rand_incomplete got=%0d beats left exp=0", exp_ch.size()); end
            exp_ch.delete(); exp_d.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_producers();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_space_gate();
        test_stall();
        test_last_early();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous width-converting FIFO (64-bit write port, narrow FWFT read port) between several producer channels. Grants whole bursts only when the FIFO has room for a full burst, so a granted producer never stalls on `full` mid-burst under normal operation. Sits directly in front of the FIFO's write port; the read side is untouched.

## Interface
- `NUM_REQ`, 4, number of producer channels (2..8)
- `DATA_WIDTH`, 64, FIFO write data width
- `FIFO_DEPTH`, 16, FIFO write depth in words (power of 2)
- `BURST_LEN`, 4, maximum beats per grant (1..FIFO_DEPTH)
- `CNT_WIDTH`, $clog2(FIFO_DEPTH)+1, width of the FIFO write data count
- `sys_clk  in  1  system clock, all logic on rising edge`
- `rstn  in  1  asynchronous, active-low reset`
- `req_valid  in  NUM_REQ  per-channel data valid`
- `req_data  in  NUM_REQ*DATA_WIDTH  per-channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]`
- `req_last  in  NUM_REQ  marks final beat of a channel's burst`
- `req_ready  out  NUM_REQ  per-channel accept; one-hot or zero`
- `fifo_din  out  DATA_WIDTH  FIFO write data`
- `fifo_wr_en  out  1  FIFO write enable`
- `fifo_full  in  1  FIFO full flag`
- `fifo_wr_data_count  in  CNT_WIDTH  FIFO write-side occupancy`
- `grant_id  out  $clog2(NUM_REQ)  currently/last granted channel`
- `busy  out  1  high while in BURST or SETTLE`
- `burst_done  out  1  one-cycle pulse when a burst closes`

## Operation
- `space = FIFO_DEPTH - fifo_wr_data_count` (CNT_WIDTH unsigned; count never exceeds depth).
- States: IDLE, BURST, SETTLE.
- IDLE: if any `req_valid` and `space >= BURST_LEN` and `fifo_full == 0`, pick winner by round-robin starting at `rr_ptr`, register `grant_id`, clear `beat_cnt`, go BURST. Otherwise stay.
- BURST: `req_ready[grant_id] = ~fifo_full`, all other ready bits 0. Beat accepted when `req_valid[g] & req_ready[g]`; `fifo_wr_en` = that, `fifo_din` = channel g's slice (combinational mux). `beat_cnt` increments per beat. Burst closes on the accepted beat where `req_last` is high or `beat_cnt` reaches `BURST_LEN-1`; go SETTLE, pulse `burst_done`, `rr_ptr <= g+1` (wraps to 0 after NUM_REQ-1). Producer dropping `req_valid` mid-burst only stalls; grant is held.
- SETTLE: 2 cycles, no writes, all ready 0, then IDLE. Covers the FIFO's registered count update so the next space check is exact.
- `fifo_full` asserted in BURST: ready drops, no write, state held (defensive; not expected).
- `fifo_din` outside BURST: 0. `req_last` outside an accepted beat ignored.

## Timing
- Reset values: `req_ready=0`, `fifo_wr_en=0`, `fifo_din=0`, `grant_id=0`, `busy=0`, `burst_done=0`, `rr_ptr=0`, state IDLE, `beat_cnt=0`.
- Grant decided at edge N; first beat earliest in cycle after N (ready high from N+1). Zero latency from `req_data` to `fifo_din`.
- `burst_done` high in the cycle after the closing beat; next grant earliest 3 cycles after closing beat.
- Max throughput: BURST_LEN beats per BURST_LEN+3 cycles.
- Reset mid-burst: all state cleared immediately; partial burst is not replayed. FIFO is reset from the same `rstn`.
- Simultaneous requests: lowest index at or after `rr_ptr` wins; a channel that just finished has lowest priority next round.

## Structure
- Package `fifo_arb_pkg`: state encodings (IDLE/BURST/SETTLE), SETTLE length constant (2).
- Sub-module `rr_arbiter`: combinational rotate-priority pick from `req_valid` and `rr_ptr`, outputs one-hot grant and encoded index. Top holds FSM, counters, datapath mux.

## Test plan
- Single channel 2 asserts valid with 4 beats, last on beat 4, count=0 -> grant_id=2, 4 writes on consecutive cycles, burst_done 1 cycle later, busy low after 2 SETTLE cycles.
- All 4 channels valid continuously -> grant order 0,1,2,3,0; each burst exactly 4 beats; din matches granting channel's data.
- count=13 (space 3), channel 0 valid -> no grant; count drops to 12 -> grant next edge.
- Channel 1 drops valid after beat 2 for 5 cycles -> no writes, grant held, beats 3-4 complete after resume.
- `req_last` on beat 1 -> 1-beat burst, rr_ptr advances.
- rstn low mid-burst at beat 2 -> wr_en, ready, busy 0 asynchronously; after release, grant restarts from channel 0.
